// File: rtl/ram_port_arbiter_pkg.sv
// Shared definitions for the RAM port arbiter: state encodings and default RAM geometry.
package ram_port_arbiter_pkg;

  typedef enum logic {
    ST_ARB   = 1'b0,
    ST_CLEAR = 1'b1
  } state_t;

  localparam int DEF_WIDTHAD = 16;
  localparam int DEF_WIDTH   = 32;

endpackage

// File: rtl/ram_port_arbiter_rr_pick.sv
// Round-robin picker: first asserted request at or above ptr, wrapping at NREQ.
module rr_pick #(
  parameter  int NREQ = 4,
  localparam int PW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   ptr,
  output logic [NREQ-1:0] grant,
  output logic [PW-1:0]   winner
);

  int   idx;
  logic found;

  always_comb begin
    grant  = '0;
    winner = ptr;
    found  = 1'b0;
    idx    = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = int'(ptr) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!found && req[idx]) begin
        found  = 1'b1;
        winner = PW'(idx);
      end
    end
    if (found) grant[winner] = 1'b1;
  end

endmodule

// File: rtl/ram_port_arbiter.sv
// Round-robin sharing of RAM port A between NREQ requesters, with a zero-fill clear engine.
module ram_port_arbiter
  import ram_port_arbiter_pkg::*;
#(
  parameter int NREQ           = 4,
  parameter int WIDTHAD        = DEF_WIDTHAD,
  parameter int WIDTH          = DEF_WIDTH,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NREQ-1:0]         req_valid,
  input  logic [NREQ-1:0]         req_we,
  input  logic [NREQ*WIDTHAD-1:0] req_addr,
  input  logic [NREQ*WIDTH-1:0]   req_wdata,
  output logic [NREQ-1:0]         req_ready,
  output logic [NREQ-1:0]         resp_valid,
  output logic [WIDTH-1:0]        resp_rdata,
  input  logic                    clear_start,
  output logic                    clear_busy,
  output logic [WIDTHAD-1:0]      ram_address,
  output logic                    ram_wren,
  output logic [WIDTH-1:0]        ram_data,
  output logic                    ram_rden,
  input  logic [WIDTH-1:0]        ram_q
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  state_t             state_q, state_d;
  logic [PW-1:0]      ptr_q, ptr_d, winner;
  logic [NREQ-1:0]    pick, grant;
  logic [WIDTHAD-1:0] clr_cnt_q, addr_hold_q, sel_addr;
  logic [WIDTH-1:0]   data_hold_q, sel_wdata;
  logic               sel_we, any_grant, arb_en;

  rr_pick #(.NREQ(NREQ)) u_pick (
    .req    (req_valid),
    .ptr    (ptr_q),
    .grant  (pick),
    .winner (winner)
  );

  assign sel_addr  = req_addr[int'(winner)*WIDTHAD +: WIDTHAD];
  assign sel_wdata = req_wdata[int'(winner)*WIDTH +: WIDTH];
  assign sel_we    = req_we[winner];

  // rst_n gates the combinational drive so the RAM port goes quiet the instant reset asserts.
  assign arb_en     = rst_n && (state_q == ST_ARB);
  assign grant      = pick & {NREQ{arb_en}};
  assign any_grant  = |grant;
  assign req_ready  = grant;
  assign clear_busy = (state_q == ST_CLEAR);
  assign resp_rdata = (|resp_valid) ? ram_q : '0;

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    ram_address = addr_hold_q;
    ram_data    = data_hold_q;
    ram_wren    = 1'b0;
    ram_rden    = 1'b0;
    case (state_q)
      ST_ARB: begin
        if (any_grant) begin
          ram_address = sel_addr;
          ram_data    = sel_wdata;
          ram_wren    = sel_we;
          ram_rden    = ~sel_we;
          ptr_d       = (winner == PW'(NREQ-1)) ? '0 : winner + 1'b1;
        end
        if (clear_start) state_d = ST_CLEAR;
      end
      ST_CLEAR: begin
        ram_address = clr_cnt_q;
        ram_data    = '0;
        ram_wren    = rst_n;
        if (&clr_cnt_q) state_d = ST_ARB;
      end
      default: state_d = ST_ARB;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= CLEAR_ON_RESET ? ST_CLEAR : ST_ARB;
      ptr_q       <= '0;
      clr_cnt_q   <= '0;
      addr_hold_q <= '0;
      data_hold_q <= '0;
      resp_valid  <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      // The counter wraps to 0 on the last sweep write, so the next sweep starts clean.
      clr_cnt_q   <= (state_q == ST_CLEAR) ? clr_cnt_q + 1'b1 : '0;
      addr_hold_q <= ram_address;
      data_hold_q <= ram_data;
      resp_valid  <= sel_we ? '0 : grant;
    end
  end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed bench for ram_port_arbiter with a 16-word behavioural RAM on port A.
module tb_ram_port_arbiter;

  localparam int NREQ = 4;
  localparam int WA   = 4;
  localparam int W    = 32;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [NREQ-1:0]   req_valid = '0, req_we = '0;
  logic [NREQ*WA-1:0] req_addr = '0;
  logic [NREQ*W-1:0] req_wdata = '0;
  logic [NREQ-1:0]   req_ready, resp_valid;
  logic [W-1:0]      resp_rdata;
  logic              clear_start = 1'b0;
  logic              clear_busy;
  logic [WA-1:0]     ram_address;
  logic              ram_wren, ram_rden;
  logic [W-1:0]      ram_data;
  logic [W-1:0]      ram_q = '0;
  logic [W-1:0]      mem [0:15];

  int errors = 0;
  int checks = 0;
  logic [W-1:0] dval [0:3];

  ram_port_arbiter #(.NREQ(NREQ), .WIDTHAD(WA), .WIDTH(W), .CLEAR_ON_RESET(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_ready(req_ready), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .clear_start(clear_start), .clear_busy(clear_busy), .ram_address(ram_address),
    .ram_wren(ram_wren), .ram_data(ram_data), .ram_rden(ram_rden), .ram_q(ram_q)
  );

  always #5 clk = ~clk;

  initial for (int i = 0; i < 16; i++) mem[i] = 32'hA5A5_0000 | i;

  always @(posedge clk) begin
    if (ram_wren) mem[ram_address] <= ram_data;
    if (ram_rden) ram_q <= mem[ram_address];
  end

  task automatic set_req(input int i, input bit v, input bit we, input logic [WA-1:0] a,
                         input logic [W-1:0] d);
    req_valid[i]        = v;
    req_we[i]           = we;
    req_addr[i*WA +: WA] = a;
    req_wdata[i*W +: W] = d;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if ({req_ready, resp_valid, resp_rdata, ram_wren, ram_rden, ram_address, ram_data} !== '0) begin
      errors++;
      $display("FAIL reset_outputs ready=%b rv=%b rdata=%h wren=%b rden=%b addr=%h data=%h exp all zero",
               req_ready, resp_valid, resp_rdata, ram_wren, ram_rden, ram_address, ram_data);
    end
    checks++;
    if (clear_busy !== 1'b1) begin errors++; $display("FAIL reset_busy got=%b exp=1", clear_busy); end
    @(negedge clk);
    rst_n = 1'b1;
    req_valid = 4'b1111;
    for (int c = 0; c < 16; c++) begin
      if (c > 0) @(negedge clk);
      #1;
      checks++;
      if ({clear_busy, ram_wren, ram_rden, ram_address, req_ready, ram_data} !== {1'b1, 1'b1, 1'b0, 4'(c), 4'b0000, 32'h0}) begin
        errors++;
        $display("FAIL sweep_c%0d busy=%b wren=%b rden=%b addr=%0d ready=%b data=%h exp 1 1 0 %0d 0000 0",
                 c, clear_busy, ram_wren, ram_rden, ram_address, req_ready, ram_data, c);
      end
    end
    @(negedge clk);
    req_valid = '0;
    #1;
    checks++;
    if ({clear_busy, ram_wren} !== 2'b00) begin
      errors++; $display("FAIL sweep_end busy=%b wren=%b exp 0 0", clear_busy, ram_wren);
    end
    checks++;
    begin
      int nz = 0;
      for (int i = 0; i < 16; i++) if (mem[i] !== '0) nz++;
      if (nz != 0) begin errors++; $display("FAIL sweep_mem nonzero_words=%0d exp 0", nz); end
    end
    @(negedge clk);
    set_req(3, 1, 0, 4'd5, '0);
    #1;
    checks++;
    if ({req_ready, ram_rden, ram_address} !== {4'b1000, 1'b1, 4'd5}) begin
      errors++; $display("FAIL read5_grant ready=%b rden=%b addr=%0d exp 1000 1 5", req_ready, ram_rden, ram_address);
    end
    @(negedge clk);
    req_valid = '0;
    #1;
    checks++;
    if ({resp_valid, resp_rdata} !== {4'b1000, 32'h0}) begin
      errors++; $display("FAIL read5_resp rv=%b rdata=%h exp 1000 0", resp_valid, resp_rdata);
    end
  endtask

  task automatic test_round_robin();
    for (int i = 0; i < 4; i++) dval[i] = 32'h1000_00A0 + i;
    @(negedge clk);
    for (int i = 0; i < 4; i++) set_req(i, 1, 1, 4'(10 + i), dval[i]);
    for (int k = 0; k < 4; k++) begin
      if (k > 0) @(negedge clk);
      #1;
      checks++;
      if ({req_ready, ram_wren, ram_address, ram_data} !== {4'b0001 << k, 1'b1, 4'(10 + k), dval[k]}) begin
        errors++;
        $display("FAIL rr_write_k%0d ready=%b wren=%b addr=%0d data=%h exp %b 1 %0d %h",
                 k, req_ready, ram_wren, ram_address, ram_data, 4'b0001 << k, 10 + k, dval[k]);
      end
    end
    @(negedge clk);
    req_we = '0;
    for (int k = 0; k < 5; k++) begin
      if (k > 0) @(negedge clk);
      #1;
      checks++;
      if ({req_ready, ram_rden, ram_address} !== {4'b0001 << (k % 4), 1'b1, 4'(10 + k % 4)}) begin
        errors++;
        $display("FAIL rr_read_grant_k%0d ready=%b rden=%b addr=%0d exp %b 1 %0d",
                 k, req_ready, ram_rden, ram_address, 4'b0001 << (k % 4), 10 + k % 4);
      end
      checks++;
      if (k == 0) begin
        if (resp_valid !== 4'b0000) begin errors++; $display("FAIL rr_resp_k0 rv=%b exp 0000", resp_valid); end
      end else if ({resp_valid, resp_rdata} !== {4'b0001 << ((k - 1) % 4), dval[(k - 1) % 4]}) begin
        errors++;
        $display("FAIL rr_resp_k%0d rv=%b rdata=%h exp %b %h",
                 k, resp_valid, resp_rdata, 4'b0001 << ((k - 1) % 4), dval[(k - 1) % 4]);
      end
    end
    @(negedge clk);
    req_valid = '0;
    #1;
    checks++;
    if ({resp_valid, resp_rdata} !== {4'b0001, dval[0]}) begin
      errors++; $display("FAIL rr_resp_last rv=%b rdata=%h exp 0001 %h", resp_valid, resp_rdata, dval[0]);
    end
  endtask

  task automatic test_write_then_read();
    @(negedge clk);
    req_valid = '0;
    set_req(2, 1, 1, 4'd7, 32'hDEAD_BEEF);
    #1;
    checks++;
    if ({req_ready, ram_wren, ram_address} !== {4'b0100, 1'b1, 4'd7}) begin
      errors++; $display("FAIL wr_grant ready=%b wren=%b addr=%0d exp 0100 1 7", req_ready, ram_wren, ram_address);
    end
    @(negedge clk);
    req_valid = '0;
    set_req(0, 1, 0, 4'd7, '0);
    #1;
    checks++;
    if ({req_ready, ram_rden, resp_valid} !== {4'b0001, 1'b1, 4'b0000}) begin
      errors++; $display("FAIL rd_grant ready=%b rden=%b rv=%b exp 0001 1 0000", req_ready, ram_rden, resp_valid);
    end
    @(negedge clk);
    req_valid = '0;
    #1;
    checks++;
    if ({resp_valid, resp_rdata} !== {4'b0001, 32'hDEAD_BEEF}) begin
      errors++; $display("FAIL wr_rd_resp rv=%b rdata=%h exp 0001 deadbeef", resp_valid, resp_rdata);
    end
  endtask

  task automatic test_single_requester();
    @(negedge clk);
    req_valid = '0;
    set_req(3, 1, 0, 4'd10, '0);
    for (int k = 0; k < 5; k++) begin
      if (k > 0) @(negedge clk);
      #1;
      checks++;
      if (req_ready !== 4'b1000) begin errors++; $display("FAIL solo3_k%0d ready=%b exp 1000", k, req_ready); end
      if (k > 0) begin
        checks++;
        if ({resp_valid, resp_rdata} !== {4'b1000, dval[0]}) begin
          errors++; $display("FAIL solo3_resp_k%0d rv=%b rdata=%h exp 1000 %h", k, resp_valid, resp_rdata, dval[0]);
        end
      end
    end
    @(negedge clk);
    set_req(1, 1, 0, 4'd11, '0);
    #1;
    checks++;
    if (req_ready !== 4'b0010) begin errors++; $display("FAIL pair_first ready=%b exp 0010", req_ready); end
    @(negedge clk);
    #1;
    checks++;
    if (req_ready !== 4'b1000) begin errors++; $display("FAIL pair_second ready=%b exp 1000", req_ready); end
    @(negedge clk);
    req_valid = '0;
  endtask

  task automatic test_clear_collision();
    set_req(1, 1, 1, 4'd2, 32'h1234_5678);
    #1;
    checks++;
    if ({req_ready, ram_wren} !== {4'b0010, 1'b1}) begin
      errors++; $display("FAIL col_write ready=%b wren=%b exp 0010 1", req_ready, ram_wren);
    end
    @(negedge clk);
    set_req(1, 1, 0, 4'd2, '0);
    clear_start = 1'b1;
    #1;
    checks++;
    if ({req_ready, ram_rden, clear_busy} !== {4'b0010, 1'b1, 1'b0}) begin
      errors++; $display("FAIL col_grant ready=%b rden=%b busy=%b exp 0010 1 0", req_ready, ram_rden, clear_busy);
    end
    @(negedge clk);
    clear_start = 1'b0;
    #1;
    checks++;
    if ({resp_valid, resp_rdata} !== {4'b0010, 32'h1234_5678}) begin
      errors++; $display("FAIL col_resp rv=%b rdata=%h exp 0010 12345678", resp_valid, resp_rdata);
    end
    for (int c = 0; c < 16; c++) begin
      if (c > 0) begin
        @(negedge clk);
        clear_start = (c == 5);
      end
      #1;
      checks++;
      if ({clear_busy, ram_wren, ram_address, req_ready} !== {1'b1, 1'b1, 4'(c), 4'b0000}) begin
        errors++;
        $display("FAIL col_sweep_c%0d busy=%b wren=%b addr=%0d ready=%b exp 1 1 %0d 0000",
                 c, clear_busy, ram_wren, ram_address, req_ready, c);
      end
    end
    @(negedge clk);
    clear_start = 1'b0;
    #1;
    checks++;
    if ({clear_busy, req_ready, ram_rden} !== {1'b0, 4'b0010, 1'b1}) begin
      errors++; $display("FAIL col_after busy=%b ready=%b rden=%b exp 0 0010 1", clear_busy, req_ready, ram_rden);
    end
    @(negedge clk);
    req_valid = '0;
    #1;
    checks++;
    if ({resp_valid, resp_rdata} !== {4'b0010, 32'h0}) begin
      errors++; $display("FAIL col_cleared rv=%b rdata=%h exp 0010 0", resp_valid, resp_rdata);
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    clear_start = 1'b1;
    #1;
    checks++;
    if (clear_busy !== 1'b0) begin errors++; $display("FAIL mid_start busy=%b exp 0", clear_busy); end
    @(negedge clk);
    clear_start = 1'b0;
    for (int c = 0; c < 6; c++) begin
      if (c > 0) @(negedge clk);
      #1;
      checks++;
      if ({clear_busy, ram_address} !== {1'b1, 4'(c)}) begin
        errors++; $display("FAIL mid_pre_c%0d busy=%b addr=%0d exp 1 %0d", c, clear_busy, ram_address, c);
      end
    end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({req_ready, resp_valid, ram_wren, ram_rden, ram_address, ram_data, clear_busy} !== {12'h0, 32'h0, 1'b1}) begin
      errors++;
      $display("FAIL mid_rst ready=%b rv=%b wren=%b rden=%b addr=%0d data=%h busy=%b exp zeros busy=1",
               req_ready, resp_valid, ram_wren, ram_rden, ram_address, ram_data, clear_busy);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 16; c++) begin
      if (c > 0) @(negedge clk);
      #1;
      checks++;
      if ({clear_busy, ram_wren, ram_address} !== {1'b1, 1'b1, 4'(c)}) begin
        errors++; $display("FAIL mid_restart_c%0d busy=%b wren=%b addr=%0d exp 1 1 %0d", c, clear_busy, ram_wren, ram_address, c);
      end
    end
    @(negedge clk);
    set_req(0, 1, 0, 4'd10, '0);
    #1;
    checks++;
    if ({clear_busy, req_ready} !== {1'b0, 4'b0001}) begin
      errors++; $display("FAIL inflight_grant busy=%b ready=%b exp 0 0001", clear_busy, req_ready);
    end
    #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({req_ready, ram_rden} !== {4'b0000, 1'b0}) begin
      errors++; $display("FAIL inflight_rst ready=%b rden=%b exp 0000 0", req_ready, ram_rden);
    end
    @(negedge clk);
    req_valid = '0;
    rst_n = 1'b1;
    for (int c = 0; c < 16; c++) begin
      if (c > 0) @(negedge clk);
      #1;
      checks++;
      if ({resp_valid, resp_rdata, ram_address, clear_busy} !== {4'b0000, 32'h0, 4'(c), 1'b1}) begin
        errors++;
        $display("FAIL inflight_c%0d rv=%b rdata=%h addr=%0d busy=%b exp 0000 0 %0d 1",
                 c, resp_valid, resp_rdata, ram_address, clear_busy, c);
      end
    end
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout after %0t", $time);
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_round_robin();
    test_write_then_read();
    test_single_requester();
    test_clear_collision();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ram_port_arbiter.md
Name: ram_port_arbiter

Overview:
- Shares one port of the dual-port block RAM (M10K, 1-cycle read latency, unregistered q) between NREQ requesters.
- Round-robin, one access per cycle.
- Includes a hardware clear engine that zero-fills the RAM after reset or on command.
- Sits between core-side clients (fetch, load/store, DMA) and port A of the RAM; port B is untouched.

Parameters:
- NREQ, 4, number of requesters (2..8).
- WIDTHAD, 16, RAM address width.
- WIDTH, 32, RAM data width.
- CLEAR_ON_RESET, 1, when 1 the clear engine runs automatically on reset release.

Ports:
- clk  in  1  system clock; all logic rising-edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  NREQ  per-requester request valid.
- req_we  in  NREQ  per-requester write enable (0 = read).
- req_addr  in  NREQ*WIDTHAD  flattened addresses; slice i = [i*WIDTHAD +: WIDTHAD].
- req_wdata  in  NREQ*WIDTH  flattened write data.
- req_ready  out  NREQ  one-hot grant; a transfer occurs when valid & ready.
- resp_valid  out  NREQ  one-hot read-data valid.
- resp_rdata  out  WIDTH  read data, shared by all requesters.
- clear_start  in  1  pulse: begin zero-fill.
- clear_busy  out  1  high while the clear engine owns the port.
- ram_address  out  WIDTHAD  to RAM address_a.
- ram_wren  out  1  to RAM wren_a.
- ram_data  out  WIDTH  to RAM data_a.
- ram_rden  out  1  to RAM rden_a.
- ram_q  in  WIDTH  from RAM q_a.

Behaviour:
- Reset values:
  - req_ready = 0, resp_valid = 0, resp_rdata = 0.
  - ram_wren = 0, ram_rden = 0, ram_address = 0, ram_data = 0.
  - Round-robin pointer = 0.
  - State = CLEAR with clear_busy = 1 if CLEAR_ON_RESET, else state = ARB with clear_busy = 0.
- States:
  - ARB: normal arbitration.
  - CLEAR: zero-fill sweep.
  - CLEAR → ARB after the write to address 2^WIDTHAD-1.
  - ARB → CLEAR on clear_start = 1.
  - clear_start is ignored while in CLEAR (no restart).
- ARB grant:
  - Combinational, same cycle.
  - Winner = first i with req_valid[i] = 1, searching from pointer upward with wrap at NREQ.
  - req_ready[winner] = 1 only; no grant when no valid.
  - req_ready never asserts without the matching req_valid.
- RAM drive in ARB:
  - ram_address = req_addr[winner], ram_data = req_wdata[winner].
  - ram_wren = req_we[winner] & grant; ram_rden = ~req_we[winner] & grant.
  - With no grant: wren = rden = 0; address and data hold their previous value (registered mux select).
- Pointer update: after a grant to i, pointer = (i+1) mod NREQ on the next edge; unchanged when there is no grant.
- Read response:
  - A read granted in cycle t gives resp_valid[i] = 1 in cycle t+1, for one cycle.
  - resp_rdata = ram_q in that cycle.
  - Reads issue back-to-back; one response per cycle, in order.
- Writes produce no response.
  - A read of the same address in the next cycle returns the new data.
- CLEAR:
  - Counter walks 0 → 2^WIDTHAD-1, one address per cycle.
  - ram_wren = 1, ram_data = 0, all req_ready = 0.
  - clear_busy drops in the cycle after the last write.
  - Total duration: 2^WIDTHAD cycles.
- clear_start in a cycle where ARB grants a read:
  - That read completes and its response appears at t+1 while CLEAR begins.
  - The read is not dropped.
- Simultaneous clear_start and a grant in the same cycle: the grant is honoured and CLEAR starts next cycle.
- Reset mid-operation: all state returns to reset values immediately and asynchronously; in-flight responses are discarded, never presented.
- Requester holding valid without ready: must keep addr, we and wdata stable; the arbiter does not latch them.

Decomposition:
- Shared package/include mem_defs: state encodings (ST_ARB, ST_CLEAR) and the default WIDTHAD/WIDTH constants.
- One sub-module rr_pick: parameterised NREQ round-robin picker.
  - Inputs: request vector, pointer.
  - Outputs: one-hot grant, winner index.
  - Purely combinational.

Test Plan:
- Reset clear, CLEAR_ON_RESET = 1, WIDTHAD = 4:
  - Release rst_n → clear_busy high exactly 16 cycles with ram_wren = 1 and addresses 0..15.
  - All req_ready = 0 throughout; read of address 5 afterwards → 0.
- All four requesters valid reading addresses 10, 11, 12, 13 continuously:
  - Grants rotate 0, 1, 2, 3, 0.
  - resp_valid follows one cycle behind, with data from the matching address.
- Requester 2 writes 0xDEADBEEF to address 7 in cycle t, requester 0 reads address 7 in cycle t+1:
  - resp_valid[0] at t+2 with rdata = 0xDEADBEEF.
- Only requester 3 valid for 5 cycles:
  - Granted every cycle, pointer stays at 0.
  - Then requesters 1 and 3 valid → 1 granted first, then 3.
- clear_start asserted in the same cycle requester 1's read of address 2 is granted:
  - resp_valid[1] next cycle with the old data.
  - clear_busy high from that same next cycle; a second clear_start mid-sweep has no effect.
- rst_n pulsed low mid-sweep and during an outstanding read:
  - Outputs zero immediately, no spurious resp_valid.
  - Sweep restarts from address 0.
